// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared state type, width constants and operand ordering for the repeated-addition multiplier
package mul_pkg;

  // Operand width used when the instantiating block does not override it.
  localparam int MUL_DEFAULT_WIDTH = 16;

  // Widest operand the ordering helper can handle; narrower operands are zero-extended.
  localparam int MUL_MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

  typedef struct packed {
    logic [MUL_MAX_WIDTH-1:0] lo;
    logic [MUL_MAX_WIDTH-1:0] hi;
  } mul_pair_t;

  // Orders two unsigned operands so the smaller one can be used as the loop count.
  function automatic mul_pair_t mul_order_pair(input logic [MUL_MAX_WIDTH-1:0] x,
                                               input logic [MUL_MAX_WIDTH-1:0] y);
    mul_pair_t p;
    if (x < y) begin
      p.lo = x;
      p.hi = y;
    end else begin
      p.lo = y;
      p.hi = x;
    end
    return p;
  endfunction

endpackage

// File: rtl/mul_repadd_ctrl.sv
// rtl/mul_repadd_ctrl.sv - IDLE/ADD/DONE sequencer producing load, count-down, accumulate and finish strobes
module mul_repadd_ctrl
  import mul_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic cnt_zero,
  output logic load,
  output logic dec,
  output logic acc_en,
  output logic finish,
  output logic busy,
  output logic done
);

  mul_state_t state;
  mul_state_t state_next;

  // State register; reset drops any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and strobe decode; start is only looked at in IDLE, so it is never queued.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    dec        = 1'b0;
    acc_en     = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_ADD;
        end
      end
      ST_ADD: begin
        if (cnt_zero) begin
          state_next = ST_DONE;
        end else begin
          dec    = 1'b1;
          acc_en = 1'b1;
        end
      end
      ST_DONE: begin
        finish     = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Registered status: busy spans accept to completion, done pulses as busy falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        busy <= 1'b1;
      end else if (finish) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mul_repadd_unit.sv
// rtl/mul_repadd_unit.sv - repeated-addition multiplier top; MUL_REPADD_SIGNED_EN selects two's-complement operands
module mul_repadd_unit
  import mul_pkg::*;
#(
  parameter int WIDTH    = MUL_DEFAULT_WIDTH,
  parameter int SWAP_MIN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  logic [2*WIDTH-1:0]       acc;
  logic [WIDTH-1:0]         cnt;
  logic [WIDTH-1:0]         addend;

  logic [WIDTH-1:0]         a_op;
  logic [WIDTH-1:0]         b_op;
  logic [WIDTH-1:0]         addend_load;
  logic [WIDTH-1:0]         cnt_load;
  logic [MUL_MAX_WIDTH-1:0] a_ext;
  logic [MUL_MAX_WIDTH-1:0] b_ext;
  mul_pair_t                pair;
  logic [2*WIDTH-1:0]       result;

  logic load;
  logic dec;
  logic acc_en;
  logic finish;
  logic cnt_zero;

  localparam logic [WIDTH-1:0] CNT_STEP = {{(WIDTH-1){1'b0}}, 1'b1};

  assign cnt_zero = (cnt == '0);

`ifdef MUL_REPADD_SIGNED_EN
  logic sign_load;
  logic sign_q;

  // Magnitudes are taken as WIDTH-bit unsigned so the most negative value still fits.
  assign a_op      = a_in[WIDTH-1] ? -a_in : a_in;
  assign b_op      = b_in[WIDTH-1] ? -b_in : b_in;
  assign sign_load = a_in[WIDTH-1] ^ b_in[WIDTH-1];
  assign result    = sign_q ? -acc : acc;

  // Sign of the result is captured with the operands and applied only at completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q <= 1'b0;
    end else if (load) begin
      sign_q <= sign_load;
    end
  end
`else
  assign a_op   = a_in;
  assign b_op   = b_in;
  assign result = acc;
`endif

  // Choose addend and loop count; with swapping the smaller operand bounds the latency.
  always_comb begin
    a_ext              = '0;
    b_ext              = '0;
    a_ext[WIDTH-1:0]   = a_op;
    b_ext[WIDTH-1:0]   = b_op;
    pair               = mul_order_pair(a_ext, b_ext);
    if (SWAP_MIN != 0) begin
      addend_load = WIDTH'(pair.hi);
      cnt_load    = WIDTH'(pair.lo);
    end else begin
      addend_load = a_op;
      cnt_load    = b_op;
    end
  end

  mul_repadd_ctrl u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cnt_zero (cnt_zero),
    .load     (load),
    .dec      (dec),
    .acc_en   (acc_en),
    .finish   (finish),
    .busy     (busy),
    .done     (done)
  );

  // Datapath: load operands on accept, add once per count, publish on finish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      addend  <= '0;
      product <= '0;
    end else begin
      if (load) begin
        addend <= addend_load;
        cnt    <= cnt_load;
        acc    <= '0;
      end else begin
        if (acc_en) begin
          acc <= acc + {{WIDTH{1'b0}}, addend};
        end
        if (dec) begin
          cnt <= cnt - CNT_STEP;
        end
      end
      if (finish) begin
        product <= result;
      end
    end
  end

endmodule
